// File: rtl/lane_btn_conditioner.sv
// Lane switch conditioner: per-lane two-flop synchroniser, debounce FSM and
// press/release edge pulses, plus a lowest-index press encoder.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sw_raw       : raw asynchronous lane inputs (bit i = lane i)
//   btn_level    : debounced level per lane
//   btn_press    : one-cycle pulse on an accepted 0->1 change
//   btn_release  : one-cycle pulse on an accepted 1->0 change
//   press_any    : OR of btn_press
//   press_lane   : lowest lane index with btn_press set (0 when none)
//   multi_press  : more than one btn_press bit set in the same cycle
module lane_btn_conditioner #(
  parameter int unsigned NUM_LANES = 6,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] sw_raw,
  output logic [NUM_LANES-1:0] btn_level,
  output logic [NUM_LANES-1:0] btn_press,
  output logic [NUM_LANES-1:0] btn_release,
  output logic                 press_any,
  output logic [2:0]           press_lane,
  output logic                 multi_press
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [NUM_LANES-1:0] sync1;
  logic [NUM_LANES-1:0] sync2;

  state_t               state_q [NUM_LANES];
  state_t               state_d [NUM_LANES];
  logic [CNT_W-1:0]     cnt_q   [NUM_LANES];
  logic [CNT_W-1:0]     cnt_d   [NUM_LANES];

  logic [NUM_LANES-1:0] level_d;
  logic [NUM_LANES-1:0] press_d;
  logic [NUM_LANES-1:0] release_d;
  logic                 any_d;
  logic [2:0]           lane_d;
  logic                 multi_d;
  int unsigned          n_press;

  // Two-flop synchroniser for the asynchronous lane inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-lane debounce next-state, plus the press encoder fed from the next pulses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    any_d     = 1'b0;
    lane_d    = 3'd0;
    multi_d   = 1'b0;
    n_press   = 0;

    for (int i = 0; i < NUM_LANES; i++) begin
      case (state_q[i])
        STABLE_LO: begin
          cnt_d[i] = '0;
          if (sync2[i]) begin
            state_d[i] = WAIT_HI;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!sync2[i]) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          cnt_d[i] = '0;
          if (!sync2[i]) begin
            state_d[i] = WAIT_LO;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (sync2[i]) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i]   = STABLE_LO;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = STABLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end

    // Scan downward so the lowest set lane wins
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (press_d[i]) begin
        lane_d = 3'(i);
      end
      n_press = n_press + 32'(press_d[i]);
    end
    any_d   = |press_d;
    multi_d = (n_press > 32'd1);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      press_any   <= 1'b0;
      press_lane  <= 3'd0;
      multi_press <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      press_any   <= any_d;
      press_lane  <= lane_d;
      multi_press <= multi_d;
    end
  end

endmodule

// File: tb/tb_lane_btn_conditioner.sv
// Bench for lane_btn_conditioner: directed scenarios plus random lane activity,
// compared every cycle against a window-based reference model.
module tb_lane_btn_conditioner;

  localparam int unsigned NL = 6;
  localparam int unsigned DB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] sw_raw;
  logic [NL-1:0] btn_level;
  logic [NL-1:0] btn_press;
  logic [NL-1:0] btn_release;
  logic          press_any;
  logic [2:0]    press_lane;
  logic          multi_press;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: raw delayed two samples, then a lane flips once the last
  // DB samples it saw all disagree with its current level.
  logic [NL-1:0] m_sync1, m_sync2, m_level, m_press, m_release;
  logic [NL-1:0] m_hist [$];

  lane_btn_conditioner #(
    .NUM_LANES (NL),
    .DB_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_raw      (sw_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .press_any   (press_any),
    .press_lane  (press_lane),
    .multi_press (multi_press)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync1   = '0;
    m_sync2   = '0;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    m_hist.delete();
  endtask

  task automatic model_step();
    bit all_opp;
    m_hist.push_back(m_sync2);
    if (m_hist.size() > int'(DB)) void'(m_hist.pop_front());
    m_press   = '0;
    m_release = '0;
    if (m_hist.size() == int'(DB)) begin
      for (int l = 0; l < NL; l++) begin
        all_opp = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][l] == m_level[l]) all_opp = 1'b0;
        if (all_opp) begin
          if (m_level[l]) m_release[l] = 1'b1;
          else            m_press[l]   = 1'b1;
          m_level[l] = ~m_level[l];
        end
      end
    end
    m_sync2 = m_sync1;
    m_sync1 = sw_raw;
  endtask

  function automatic logic [2:0] model_lane(input logic [NL-1:0] p);
    for (int l = 0; l < NL; l++) if (p[l]) return 3'(l);
    return 3'd0;
  endfunction

  task automatic compare_all();
    check_eq("level",   32'(btn_level),   32'(m_level));
    check_eq("press",   32'(btn_press),   32'(m_press));
    check_eq("release", 32'(btn_release), 32'(m_release));
    check_eq("any",     32'(press_any),   32'(|m_press));
    check_eq("lane",    32'(press_lane),  32'(model_lane(m_press)));
    check_eq("multi",   32'(multi_press), 32'($countones(m_press) > 1));
  endtask

  // One clock: sample away from the edge, advance the model, compare
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) model_step();
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_level", 32'(btn_level), 32'd0);
  endtask

  task automatic expect_press(input int lane, input int edge_n, input int n_ticks);
    for (int k = 1; k <= n_ticks; k++) begin
      tick();
      check_eq($sformatf("press%0d_e%0d", lane, k), 32'(btn_press[lane]), 32'(k == edge_n));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = 6'h3F;
    model_reset();

    // 1: reset held with all lanes high, then one combined press
    #1;
    for (int k = 0; k < 3; k++) begin
      compare_all();
      check_eq("rst_press", 32'(btn_press), 32'd0);
      check_eq("rst_multi", 32'(multi_press), 32'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 6) check_eq("t1_level_pre", 32'(btn_level), 32'd0);
      if (k == 6) begin
        check_eq("t1_level", 32'(btn_level), 32'h3F);
        check_eq("t1_press", 32'(btn_press), 32'h3F);
        check_eq("t1_multi", 32'(multi_press), 32'd1);
        check_eq("t1_lane",  32'(press_lane), 32'd0);
      end
      if (k == 7) check_eq("t1_press_off", 32'(btn_press), 32'd0);
    end
    sw_raw = '0;
    ticks(10);

    // 2: lane 2 rises and holds
    sw_raw[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_eq("t2_press2", 32'(btn_press[2]), 32'(k == 6));
      if (k == 6) check_eq("t2_lane", 32'(press_lane), 32'd2);
      if (k >= 6) check_eq("t2_level2", 32'(btn_level[2]), 32'd1);
    end

    // 3: lane 4 bounces then holds
    for (int k = 0; k < 4; k++) begin
      sw_raw[4] = (k % 2 == 0);
      tick();
      check_eq("t3_bounce", 32'(btn_press[4]), 32'd0);
    end
    sw_raw[4] = 1'b1;
    expect_press(4, 6, 10);

    // 4: three-cycle glitch on lane 1
    sw_raw[1] = 1'b1;
    ticks(3);
    sw_raw[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("t4_level1", 32'(btn_level[1]), 32'd0);
      check_eq("t4_edge1",  32'(btn_press[1] | btn_release[1]), 32'd0);
    end

    // 5: lanes 3 and 5 together
    sw_raw[3] = 1'b1;
    sw_raw[5] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) begin
        check_eq("t5_press", 32'(btn_press), 32'b101000);
        check_eq("t5_lane",  32'(press_lane), 32'd3);
        check_eq("t5_multi", 32'(multi_press), 32'd1);
      end else begin
        check_eq("t5_quiet", 32'(btn_press & 6'b101000), 32'd0);
      end
    end

    // 6: lane 0 high, then reset while it is debouncing low
    sw_raw[0] = 1'b1;
    ticks(8);
    sw_raw[0] = 1'b0;
    ticks(4);
    check_eq("t6_level_hold", 32'(btn_level[0]), 32'd1);
    sw_raw[0] = 1'b1;
    assert_reset();
    ticks(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_eq("t6_press0", 32'(btn_press[0]), 32'(k == 6));
      check_eq("t6_release", 32'(btn_release), 32'd0);
    end

    // Random lane activity with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < NL; l++)
        if ($urandom_range(0, 19) == 0) sw_raw[l] = ~sw_raw[l];
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        ticks(2);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
